// File: rtl/drv_switch_matrix_scan.sv
// Keypad matrix scanner: drives one column low at a time and debounces every key by
// counting consecutive disagreeing scans. Press/release events are queued in a FIFO.
module drv_switch_matrix_scan #(
  parameter int p_ROWS       = 4,
  parameter int p_COLS       = 4,
  parameter int p_SETTLE     = 16,
  parameter int p_FILTER     = 5,
  parameter int p_FIFO_DEPTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic [p_ROWS-1:0]                i_row,
  output logic [p_COLS-1:0]                o_col,
  output logic                             o_evt_valid,
  input  logic                             i_evt_ready,
  output logic [$clog2(p_ROWS*p_COLS)-1:0] o_evt_code,
  output logic                             o_evt_press,
  output logic [p_ROWS*p_COLS-1:0]         o_keys,
  output logic                             o_any,
  output logic                             o_overflow
);

  localparam int NK = p_ROWS * p_COLS;
  localparam int CW = $clog2(NK);
  localparam int RW = (p_ROWS > 1) ? $clog2(p_ROWS) : 1;
  localparam int LW = (p_COLS > 1) ? $clog2(p_COLS) : 1;
  localparam int SW = $clog2(p_SETTLE + 1);
  localparam int FW = $clog2(p_FILTER + 1);
  localparam int AW = $clog2(p_FIFO_DEPTH);
  localparam int DW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_NEXT   = 2'd3
  } state_e;

  state_e            state_q;
  logic [LW-1:0]     col_q;
  logic [LW-1:0]     col_next_s;
  logic [RW-1:0]     row_q;
  logic [SW-1:0]     settle_q;
  logic [p_ROWS-1:0] latch_q;
  logic [p_COLS-1:0] col_drv_q;

  logic [NK-1:0]     keys_q;
  logic [NK-1:0]     keys_d;
  logic              any_q;
  logic [FW-1:0]     cnt_q [NK];
  logic [FW-1:0]     cnt_cur_s;
  logic [FW-1:0]     cnt_nxt_s;
  logic [CW-1:0]     key_idx_s;
  logic              raw_s;
  logic              evt_push_s;

  logic [DW-1:0]     mem_q [p_FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       count_q;
  logic              ovf_q;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              drop_s;
  logic [DW-1:0]     head_s;

  function automatic logic [p_COLS-1:0] col_pattern(input logic [LW-1:0] c);
    logic [p_COLS-1:0] p;
    p    = '1;
    p[c] = 1'b0;
    return p;
  endfunction

  always_comb begin
    if (col_q == LW'(p_COLS - 1)) begin
      col_next_s = '0;
    end else begin
      col_next_s = col_q + LW'(1);
    end
  end

  // Scan sequencer; the column drive is registered alongside each state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      settle_q  <= '0;
      latch_q   <= '1;
      col_drv_q <= '1;
    end else begin
      case (state_q)
        S_IDLE: begin
          settle_q <= '0;
          if (i_en) begin
            state_q   <= S_DRIVE;
            col_drv_q <= col_pattern(col_q);
          end else begin
            col_drv_q <= '1;
          end
        end
        S_DRIVE: begin
          if (settle_q == SW'(p_SETTLE - 1)) begin
            latch_q <= i_row;
            row_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        S_SAMPLE: begin
          if (row_q == RW'(p_ROWS - 1)) begin
            state_q <= S_NEXT;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        S_NEXT: begin
          col_q    <= col_next_s;
          settle_q <= '0;
          if (i_en) begin
            state_q   <= S_DRIVE;
            col_drv_q <= col_pattern(col_next_s);
          end else begin
            state_q   <= S_IDLE;
            col_drv_q <= '1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          col_drv_q <= '1;
        end
      endcase
    end
  end

  // One key per SAMPLE cycle: agreement clears its counter, p_FILTER disagreements flip it.
  always_comb begin
    key_idx_s  = CW'(row_q) * CW'(p_COLS) + CW'(col_q);
    raw_s      = ~latch_q[row_q];
    cnt_cur_s  = cnt_q[key_idx_s];
    cnt_nxt_s  = cnt_cur_s;
    keys_d     = keys_q;
    evt_push_s = 1'b0;
    if (state_q == S_SAMPLE) begin
      if (raw_s == keys_q[key_idx_s]) begin
        cnt_nxt_s = '0;
      end else if (cnt_cur_s == FW'(p_FILTER - 1)) begin
        cnt_nxt_s          = '0;
        keys_d[key_idx_s]  = raw_s;
        evt_push_s         = 1'b1;
      end else begin
        cnt_nxt_s = cnt_cur_s + FW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_cur_s;
    end
  end

  // Debounced key image and per-key counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      keys_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      keys_q <= keys_d;
      any_q  <= |keys_d;
      if (state_q == S_SAMPLE) begin
        cnt_q[key_idx_s] <= cnt_nxt_s;
      end
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == (AW + 1)'(p_FIFO_DEPTH));
  assign pop_s     = ~empty_s & i_evt_ready;
  assign push_ok_s = evt_push_s & (~full_s | pop_s);
  assign drop_s    = evt_push_s & full_s & ~pop_s;
  assign head_s    = mem_q[rd_q];

  // Event FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < p_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q] <= {key_idx_s, raw_s};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign o_col       = col_drv_q;
  assign o_keys      = keys_q;
  assign o_any       = any_q;
  assign o_overflow  = ovf_q;
  assign o_evt_valid = ~empty_s;
  assign o_evt_code  = head_s[DW-1:1];
  assign o_evt_press = head_s[0];

endmodule

// File: tb/tb_drv_switch_matrix_scan.sv
// Scoreboard bench: a per-scan keypad model predicts events; a monitor pops them on handshakes.
module tb_drv_switch_matrix_scan;

  localparam int ROWS = 4, COLS = 4, SETTLE = 16, FILTER = 5, DEPTH = 8;
  localparam int NK = ROWS * COLS;
  localparam int PERIOD = SETTLE + ROWS + 1;
  localparam int SCAN = PERIOD * COLS;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_en = 1'b0;
  logic            i_evt_ready = 1'b0;
  logic [ROWS-1:0] i_row;
  logic [COLS-1:0] o_col;
  logic            o_evt_valid;
  logic [3:0]      o_evt_code;
  logic            o_evt_press;
  logic [NK-1:0]   o_keys;
  logic            o_any;
  logic            o_overflow;

  drv_switch_matrix_scan #(
    .p_ROWS(ROWS), .p_COLS(COLS), .p_SETTLE(SETTLE), .p_FILTER(FILTER), .p_FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_row(i_row), .o_col(o_col),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready), .o_evt_code(o_evt_code),
    .o_evt_press(o_evt_press), .o_keys(o_keys), .o_any(o_any), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [NK-1:0] mat = '0;
  logic [NK-1:0] mkeys = '0;
  int            mcnt [NK];
  bit            hold_ready = 1'b0;
  bit            allow_full = 1'b0;
  bit            rnd_ready = 1'b0;
  logic          exp_ovf = 1'b0;
  logic [4:0]    exp_q [$];
  logic [3:0]    last_col = 4'hF;

  // Keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    i_row = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!o_col[c] && mat[r*COLS+c]) i_row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] pat(input int c);
    logic [3:0] p;
    p = 4'hF;
    p[c] = 1'b0;
    return p;
  endfunction

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic model_reset();
    mkeys = '0;
    exp_ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NK; i++) mcnt[i] = 0;
  endtask

  // One whole scan of the current matrix, columns then rows in ascending order.
  task automatic model_scan();
    int k;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        k = r * COLS + c;
        if (mat[k] == mkeys[k]) begin
          mcnt[k] = 0;
        end else begin
          mcnt[k]++;
          if (mcnt[k] == FILTER) begin
            mcnt[k] = 0;
            mkeys[k] = mat[k];
            if (hold_ready && exp_q.size() >= DEPTH && !allow_full) exp_ovf = 1'b1;
            else exp_q.push_back({k[3:0], mat[k]});
          end
        end
      end
    end
  endtask

  task automatic begin_scan(input logic [NK-1:0] m);
    chk("keys_at_scan_start", o_keys, mkeys);
    chk("any_at_scan_start", o_any, |mkeys);
    chk("overflow_at_scan_start", o_overflow, exp_ovf);
    mat = m;
    model_scan();
  endtask

  task automatic next_scan(input logic [NK-1:0] m);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge i_clk); #1;
      if (rnd_ready) i_evt_ready = ($urandom_range(0, 3) != 0);
      if (o_col == 4'b1110 && last_col != 4'b1110) found = 1'b1;
      last_col = o_col;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL scan_start: o_col=0x%0h, required 0xe within 300 cycles", o_col);
      finish_up();
    end
    begin_scan(m);
  endtask

  // Monitor: every handshake must match the oldest predicted event.
  always @(negedge i_clk) begin
    if (!i_rst && o_evt_valid && i_evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL event_unexpected: got code %0d press %0d, required no event",
                 o_evt_code, o_evt_press);
      end else begin
        chk("event_code_press", {o_evt_code, o_evt_press}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [NK-1:0] rmat;
    logic [NK-1:0] m;
    bit seen;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_col", o_col, 4'hF);
    chk("rst_valid", o_evt_valid, 1'b0);
    chk("rst_code", o_evt_code, 4'h0);
    chk("rst_press", o_evt_press, 1'b0);
    chk("rst_keys", o_keys, 16'h0000);
    chk("rst_any", o_any, 1'b0);
    chk("rst_overflow", o_overflow, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_en = 1'b1; i_evt_ready = 1'b1;

    // Column sequence over one full scan
    next_scan('0);
    chk("col_seq", o_col, pat(0));
    for (int i = 1; i < SCAN; i++) begin
      @(posedge i_clk); #1;
      chk("col_seq", o_col, pat(i / PERIOD));
    end
    last_col = o_col;

    // Debounce accept and release of row1/col2
    repeat (5) next_scan(16'h0040);
    next_scan(16'h0040);
    chk("key6_pressed", o_keys, 16'h0040);
    chk("key6_any", o_any, 1'b1);
    repeat (5) next_scan('0);
    next_scan('0);
    chk("key6_released", o_keys, 16'h0000);

    // Bounce reject on key 0
    for (int s = 0; s < 12; s++) begin
      next_scan((s % 2 == 0) ? 16'h0001 : 16'h0000);
      chk("bounce_key0", o_keys[0], 1'b0);
    end
    repeat (2) next_scan('0);

    // Same-column ordering: keys 0 and 12
    repeat (5) next_scan(16'h1001);
    next_scan(16'h1001);
    chk("keys_0_12", o_keys, 16'h1001);
    repeat (5) next_scan('0);
    next_scan('0);

    // Randomized matrix with bounce and random consumer backpressure
    rnd_ready = 1'b1;
    rmat = '0;
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 3) == 0) rmat = NK'($urandom);
      m = rmat;
      if ($urandom_range(0, 5) == 0) m[$urandom_range(0, NK-1)] ^= 1'b1;
      next_scan(m);
    end
    rnd_ready = 1'b0; i_evt_ready = 1'b1;
    repeat (6) next_scan('0);

    // Full FIFO with push and pop in the same cycle: no overflow
    i_evt_ready = 1'b0; hold_ready = 1'b1;
    repeat (5) next_scan(16'h00FF);
    repeat (4) next_scan(16'h01FF);
    allow_full = 1'b1;
    next_scan(16'h01FF);
    allow_full = 1'b0;
    repeat (SETTLE + 2) begin @(posedge i_clk); #1; end
    i_evt_ready = 1'b1;
    @(posedge i_clk); #1;
    i_evt_ready = 1'b0;
    next_scan(16'h01FF);
    chk("no_ovf_push_pop_full", o_overflow, 1'b0);
    hold_ready = 1'b0; i_evt_ready = 1'b1;
    next_scan(16'h01FF);
    repeat (5) next_scan('0);
    next_scan('0);

    // Overflow: nine presses with the consumer stalled
    i_evt_ready = 1'b0; hold_ready = 1'b1;
    repeat (5) next_scan(16'h03FE);
    next_scan(16'h03FE);
    chk("ovf_keys", o_keys, 16'h03FE);
    chk("ovf_sticky", o_overflow, 1'b1);
    i_evt_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_one_per_cycle", o_evt_valid, 1'b1);
      @(posedge i_clk); #1;
    end
    chk("drain_done", o_evt_valid, 1'b0);
    hold_ready = 1'b0;

    // Reset mid-DRIVE with three events queued
    i_evt_ready = 1'b0; hold_ready = 1'b1;
    repeat (5) next_scan(16'h73FE);
    next_scan(16'h73FE);
    chk("three_queued", o_evt_valid, 1'b1);
    repeat (5) begin @(posedge i_clk); #1; end
    chk("in_drive", o_col, 4'b1110);
    i_rst = 1'b1;
    #1;
    chk("midrst_col", o_col, 4'hF);
    chk("midrst_valid", o_evt_valid, 1'b0);
    chk("midrst_keys", o_keys, 16'h0000);
    chk("midrst_any", o_any, 1'b0);
    chk("midrst_overflow", o_overflow, 1'b0);
    model_reset();
    hold_ready = 1'b0; mat = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_evt_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge i_clk); #1;
      if (o_col != 4'hF) seen = 1'b1;
    end
    chk("first_col_after_reset", o_col, 4'b1110);
    last_col = o_col;
    begin_scan('0);
    repeat (2) next_scan('0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge i_clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    finish_up();
  end

endmodule

// File: doc/drv_switch_matrix_scan.md
Name: drv_switch_matrix_scan

Overview:
- Scan controller for a p_ROWS x p_COLS switch matrix.
- Drives one column low at a time and samples the active-low rows.
- Debounces every key by consecutive-scan counting and queues press/release events in a FIFO with a valid/ready output.
- Sits between the board's keypad pins and user logic. It is the multiplexed counterpart of the per-switch debounce drivers, sharing one set of row pins across all columns.

Parameters:
p_ROWS, 4, number of row inputs
p_COLS, 4, number of column drive outputs
p_SETTLE, 16, cycles a column is driven before rows are latched (>=1)
p_FILTER, 5, consecutive disagreeing scans needed to accept a new key level (>=1)
p_FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  scan enable
i_row  in  p_ROWS  row inputs, active-low (0 = key in driven column closed)
o_col  out  p_COLS  column drive, active-low
o_evt_valid  out  1  FIFO head valid
i_evt_ready  in  1  consumer accepts head
o_evt_code  out  $clog2(p_ROWS*p_COLS)  key index = row*p_COLS + col
o_evt_press  out  1  1 = press event, 0 = release event
o_keys  out  p_ROWS*p_COLS  debounced key states, bit = row*p_COLS + col
o_any  out  1  OR of o_keys
o_overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
Reset (asynchronous, immediate):
- FSM goes to IDLE; column index = 0; all debounce counters = 0.
- o_col = all 1; o_keys = 0; o_any = 0.
- FIFO empty, so o_evt_valid = 0; o_evt_code = 0; o_evt_press = 0; o_overflow = 0.
- Reset mid-scan aborts the scan and discards all events and queued data.

FSM:
- IDLE:
  - o_col = all 1.
  - When i_en = 1, go to DRIVE with the current column index.
- DRIVE:
  - o_col[col] = 0, all other bits 1.
  - Count p_SETTLE cycles.
  - On the last cycle, latch i_row into the row-latch register and go to SAMPLE with row index = 0.
- SAMPLE:
  - Lasts p_ROWS cycles and processes one row per cycle, in ascending row order. The column stays driven.
  - Per cycle, for key k = row*p_COLS + col: raw = ~latched_row[row].
  - If raw == o_keys[k], the counter for k is cleared to 0.
  - Otherwise the counter increments. When it reaches p_FILTER: set o_keys[k] = raw, clear the counter, and push event {code = k, press = raw}.
  - After the last row, go to NEXT.
- NEXT (1 cycle):
  - The column stays driven.
  - col = (col == p_COLS-1) ? 0 : col+1.
  - Go to DRIVE if i_en = 1, otherwise IDLE.
- Column period: p_SETTLE + p_ROWS + 1 cycles. Full scan: p_COLS times that.
- Deasserting i_en mid-column finishes the column, then the FSM goes to IDLE. o_keys and all counters are retained; the scan resumes at the next column.
- At most one event is generated per cycle. Counter width: $clog2(p_FILTER+1).

Output timing:
- o_keys and the FIFO write are registered. A change made in SAMPLE cycle t is visible at t+1.
- o_any is registered together with o_keys.

FIFO:
- First-in first-out; o_evt_code and o_evt_press show the head entry.
- o_evt_valid = not empty.
- A pop occurs when o_evt_valid && i_evt_ready. The head stays stable while valid && !ready.
- A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- A push into a full FIFO with no pop is dropped and sets o_overflow = 1. o_overflow clears only on reset.
- A dropped event still updates o_keys.
- An empty FIFO with a push at t gives o_evt_valid = 1 at t+1 (no bypass).

Test Plan:
1. Reset: assert i_rst mid-DRIVE with 3 events queued -> o_col = 4'b1111, o_evt_valid = 0, o_keys = 0, o_overflow = 0 in the same cycle. After release with i_en = 1, o_col = 4'b1110 is the first pattern.
2. Column sequence (defaults): i_en = 1 and no keys -> o_col cycles 1110, 1101, 1011, 0111, 1110, ..., each held 21 cycles. Full scan = 84 cycles. o_evt_valid stays 0.
3. Debounce accept: hold row1/col2 closed (i_row[1] = 0 while o_col[2] = 0) -> exactly one event, code = 6, press = 1, appearing in the 5th scan. Then o_keys[6] = 1 and o_any = 1. Opening the key for 5 scans gives code = 6, press = 0.
4. Bounce reject: key row0/col0 toggled every scan for 12 scans, then left open -> no events; o_keys[0] = 0 throughout.
5. Same-column ordering: rows 0 and 3 of col 0 close together -> two events, code 0 then code 12, in consecutive SAMPLE cycles; consumer sees 0 first.
6. Overflow and backpressure: i_evt_ready = 0 while 9 distinct presses are accepted -> 8 queued, o_overflow = 1, o_keys shows all 9 pressed. Raising i_evt_ready drains the first 8 codes in generation order, one per cycle. A push and pop in the same full cycle must not set o_overflow.
